game_core: RTL
==============

GAME_CORE -- requirements
Module: game_core

Interface
REQ-001 SHALL take parameters: BIRD_X 160 (bird left edge, px); BIRD_W 16 (bird size, px); PIPE_W 52; GAP_H 120; GROUND_Y 440 (bird-top limit); SPEED 2 (px/frame); SPACING 213; FLAP_V -7; VMAX 8; START_Y 200.
REQ-002 SHALL have ports:
- clk, in, 1: system clock, single clock domain.
- rst, in, 1: reset, synchronous, active-high.
- frame_tick, in, 1: one-cycle pulse per video frame.
- btn_flap, in, 1: debounced level.
- btn_start, in, 1: debounced level.
- btn_pause, in, 1: debounced level.
- status, out, 2: game state.
- score, out, 16: four BCD digits.
- mario, out, 16: bird top y, px.
- pipe_1, pipe_2, pipe_3, out, 32 each: [31:16] signed left-edge x, [15:0] gap-top y.
- coin, out, 32: [31:16] signed x, [15:0] y; y = 16'hFFFF means hidden.

Function
REQ-003 status encoding SHALL be 00 IDLE, 01 RUN, 10 OVER, 11 PAUSE.
REQ-004 All outputs SHALL be registered; an update caused by a frame_tick sampled high in cycle N SHALL be visible in cycle N+1.
REQ-005 Each button SHALL be edge-detected on clk (0->1 between consecutive samples).
REQ-006 A flap edge SHALL set a pending flag, which is consumed at the next RUN frame_tick. The flag SHALL be cleared on any state change.
REQ-007 FSM transitions:
- IDLE --start edge--> RUN.
- RUN --pause edge--> PAUSE.
- PAUSE --pause edge--> RUN.
- RUN --collision--> OVER.
- OVER --start edge--> IDLE.
- All other edges SHALL be ignored.
REQ-008 Entering IDLE SHALL restore the reset values of score, mario, the pipes, coin and velocity.
REQ-009 Positions SHALL change only on frame_tick while in RUN; in IDLE, PAUSE and OVER all outputs SHALL hold.
REQ-010 Bird physics per RUN tick, with vel an 8-bit signed value:
- If a flap is pending, vel = FLAP_V; otherwise vel = min(vel+1, VMAX).
- Then mario = clamp(mario+vel, 0, GROUND_Y), computed in 17-bit signed arithmetic.
REQ-011 Each pipe x SHALL decrease by SPEED per RUN tick. When the new x <= -PIPE_W, x SHALL become x + 3*SPACING and gap-top SHALL become 40 + lfsr[7:0], all in the same tick.
REQ-012 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, advancing every clk cycle regardless of state.
REQ-013 On a pipe respawn, if coin is hidden, coin SHALL become {new x + PIPE_W/2 - 8, gap-top + GAP_H/2 - 8}. A visible coin SHALL move with the pipes. Coin x <= -16 SHALL hide it.
REQ-014 Pass: a pipe whose right edge (x+PIPE_W) moves from >= BIRD_X to < BIRD_X in a tick SHALL add 1 to score.
REQ-015 Coin pickup: a bird box overlapping the visible 16x16 coin box SHALL add 1 to score and hide the coin. A pass and a pickup in the same tick SHALL add 2.
REQ-016 Score SHALL be BCD addition, saturating at 16'h9999.
REQ-017 Collision SHALL be evaluated on the new positions of the same tick. It occurs when:
- mario == GROUND_Y, or
- for any pipe, the bird box overlaps [x, x+PIPE_W) horizontally and mario < gap-top or mario+BIRD_W > gap-top+GAP_H.
REQ-018 When collision and score increments occur in the same tick, both SHALL be applied: score updates and status becomes OVER.
REQ-019 When frame_tick and a start/pause edge coincide, the FSM transition SHALL take effect first and no motion step SHALL occur in that cycle.

Reset
REQ-020 While rst is high at a clk edge, the block SHALL load:
- status 00, score 0, mario START_Y, vel 0, flap flag 0.
- pipe_1 {640, 200}, pipe_2 {853, 200}, pipe_3 {1066, 200}.
- coin 32'h0000FFFF, LFSR seed.
REQ-021 Reset SHALL override every other input in the same cycle, including mid-RUN.

Structure
REQ-022 Package game_pkg SHALL hold the status encodings, the pipe/coin field widths, the hidden-coin value and the geometry defaults.
REQ-023 The LFSR SHALL be a separate sub-module, lfsr16, with ports clk, rst, value[15:0].
REQ-024 The BCD saturating adder SHALL be a function in game_pkg.

Verification
REQ-025 Reset, then start edge, then one tick with no flap -> status 01; mario 201; pipe_1 x 638.
REQ-026 From RUN with vel 0, flap edge then tick -> mario START_Y-7. The next tick without flap -> mario START_Y-13.
REQ-027 Pipe_1 at x=-51, tick -> x 586 (=-53+639); gap-top = 40 + lfsr[7:0] as sampled that cycle.
REQ-028 Score 16'h0099, with pipe right edge moving 161->159 and coin pickup in the same tick -> score 16'h0101. Score 16'h9999 plus a pass -> stays 16'h9999.
REQ-029 No flaps from START_Y -> mario reaches 440, status 10 that tick. Further ticks change nothing. Start edge -> status 00 with all reset values restored.
REQ-030 Pause edge in RUN -> status 11, and 5 ticks leave the outputs unchanged. A second pause edge -> 01. Asserting rst mid-RUN -> reset values next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game core.
// Holds the status encodings, field widths, the hidden-coin value, the
// geometry defaults, sign-extension and BCD arithmetic helpers.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_OVER  = 2'b10,
    ST_PAUSE = 2'b11
  } game_state_e;

  // Pipe/coin words are {x[15:0] signed, y[15:0]}
  localparam int POS_X_W = 16;
  localparam int POS_Y_W = 16;

  localparam logic [15:0] COIN_HIDDEN_Y = 16'hFFFF;
  localparam logic [31:0] COIN_HIDDEN   = 32'h0000_FFFF;
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;

  // Geometry defaults (pixels, pixels per frame)
  localparam int DEF_BIRD_X   = 160;
  localparam int DEF_BIRD_W   = 16;
  localparam int DEF_PIPE_W   = 52;
  localparam int DEF_GAP_H    = 120;
  localparam int DEF_GROUND_Y = 440;
  localparam int DEF_SPEED    = 2;
  localparam int DEF_SPACING  = 213;
  localparam int DEF_FLAP_V   = -7;
  localparam int DEF_VMAX     = 8;
  localparam int DEF_START_Y  = 200;
  localparam int PIPE_X0      = 640;
  localparam int PIPE_GAP0    = 200;
  localparam int GAP_MIN      = 40;
  localparam int COIN_W       = 16;

  // Sign-extend a 16-bit screen coordinate so sums cannot wrap
  function automatic logic signed [17:0] sext18(input logic [15:0] v);
    return $signed({{2{v[15]}}, v});
  endfunction

  // Four-digit BCD add of a small increment, sticking at 9999 on overflow
  function automatic logic [15:0] bcd_sat_add(input logic [15:0] a,
                                              input logic [2:0]  inc);
    logic [15:0] r;
    logic [4:0]  d;
    logic [3:0]  cin;
    r   = 16'h0000;
    cin = {1'b0, inc};
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[4*i +: 4]} + {1'b0, cin};
      if (d > 5'd9) begin
        d   = d - 5'd10;
        cin = 4'd1;
      end else begin
        cin = 4'd0;
      end
      r[4*i +: 4] = d[3:0];
    end
    if (cin != 4'd0) begin
      r = 16'h9999;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/game_core_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running every clock.
// Ports: clk, rst (sync, active-high, loads seed), value = current state.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  logic fb_s;

  assign fb_s = value[0] ^ value[2] ^ value[3] ^ value[5];

  // Shift right, feedback enters at the top
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= LFSR_SEED;
    end else begin
      value <= {fb_s, value[15:1]};
    end
  end

endmodule

// File: rtl/game_core.sv
// Flappy-style game core: FSM, bird physics, scrolling pipes, coin, score.
// Ports: clk, rst (sync active-high), frame_tick (one pulse per frame),
// btn_flap/btn_start/btn_pause (debounced levels), status (game state),
// score (4 BCD digits), mario (bird top y), pipe_1..3 ({x signed, gap-top}),
// coin ({x signed, y}, y = FFFF hidden). All outputs are registers.
module game_core
  import game_pkg::*;
#(
  parameter int BIRD_X   = DEF_BIRD_X,
  parameter int BIRD_W   = DEF_BIRD_W,
  parameter int PIPE_W   = DEF_PIPE_W,
  parameter int GAP_H    = DEF_GAP_H,
  parameter int GROUND_Y = DEF_GROUND_Y,
  parameter int SPEED    = DEF_SPEED,
  parameter int SPACING  = DEF_SPACING,
  parameter int FLAP_V   = DEF_FLAP_V,
  parameter int VMAX     = DEF_VMAX,
  parameter int START_Y  = DEF_START_Y
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_flap,
  input  logic        btn_start,
  input  logic        btn_pause,
  output logic [1:0]  status,
  output logic [15:0] score,
  output logic [15:0] mario,
  output logic [31:0] pipe_1,
  output logic [31:0] pipe_2,
  output logic [31:0] pipe_3,
  output logic [31:0] coin
);

  localparam logic signed [17:0] BIRD_X_S = 18'(BIRD_X);
  localparam logic signed [17:0] BIRD_W_S = 18'(BIRD_W);
  localparam logic signed [17:0] PIPE_W_S = 18'(PIPE_W);
  localparam logic signed [17:0] GAP_H_S  = 18'(GAP_H);
  localparam logic signed [17:0] COIN_W_S = 18'(COIN_W);
  localparam logic signed [16:0] GROUND_S = 17'(GROUND_Y);
  localparam logic [15:0] GROUND_V = 16'(GROUND_Y);
  localparam logic [15:0] SPEED_V  = 16'(SPEED);
  localparam logic [15:0] SPAN_V   = 16'(3 * SPACING);
  localparam logic [15:0] COIN_DX  = 16'(PIPE_W / 2 - COIN_W / 2);
  localparam logic [15:0] COIN_DY  = 16'(GAP_H / 2 - COIN_W / 2);
  localparam logic [15:0] GAP_MIN_V = 16'(GAP_MIN);
  localparam logic [15:0] MARIO0   = 16'(START_Y);
  localparam logic [15:0] GAP0     = 16'(PIPE_GAP0);
  localparam logic [15:0] PX1      = 16'(PIPE_X0);
  localparam logic [15:0] PX2      = 16'(PIPE_X0 + SPACING);
  localparam logic [15:0] PX3      = 16'(PIPE_X0 + 2 * SPACING);
  localparam logic signed [7:0] FLAP_V8 = 8'(FLAP_V);
  localparam logic signed [7:0] VMAX8   = 8'(VMAX);

  game_state_e state_r, next_state_s;
  logic [15:0] score_r, mario_r;
  logic signed [7:0] vel_r;
  logic flap_r;
  logic [15:0] pipe_x_r [3];
  logic [15:0] pipe_gap_r [3];
  logic [15:0] coin_x_r, coin_y_r;
  logic flap_q_r, start_q_r, pause_q_r;
  logic flap_edge_s, start_edge_s, pause_edge_s;
  logic btn_trans_s, run_step_s, enter_idle_s;
  logic [15:0] lfsr_s;
  logic [7:0]  lfsr_unused_s;

  logic signed [7:0]  step_vel_s;
  logic signed [16:0] mario_sum_s;
  logic [15:0] step_mario_s;
  logic [15:0] nx_s [3];
  logic [15:0] step_px_s [3];
  logic [15:0] step_gap_s [3];
  logic [2:0]  respawn_s, pass_s;
  logic [15:0] cx_s, step_cx_s, step_cy_s;
  logic signed [17:0] my_s, cx18_s, cy18_s;
  logic pickup_s, collide_s;
  logic [2:0]  inc_s;
  logic [15:0] step_score_s;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_s)
  );

  // Only the low byte feeds gap placement
  assign lfsr_unused_s = lfsr_s[15:8];

  assign flap_edge_s  = btn_flap  & ~flap_q_r;
  assign start_edge_s = btn_start & ~start_q_r;
  assign pause_edge_s = btn_pause & ~pause_q_r;

  // Candidate bird, pipe, coin and score values for one motion step
  always_comb begin
    step_vel_s   = vel_r;
    mario_sum_s  = 17'sd0;
    step_mario_s = mario_r;
    respawn_s    = 3'b000;
    pass_s       = 3'b000;
    cx_s         = coin_x_r;
    step_cx_s    = coin_x_r;
    step_cy_s    = coin_y_r;
    pickup_s     = 1'b0;
    collide_s    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nx_s[i]       = pipe_x_r[i];
      step_px_s[i]  = pipe_x_r[i];
      step_gap_s[i] = pipe_gap_r[i];
    end

    if (flap_r) begin
      step_vel_s = FLAP_V8;
    end else if (vel_r >= VMAX8) begin
      step_vel_s = VMAX8;
    end else begin
      step_vel_s = vel_r + 8'sd1;
    end

    mario_sum_s = $signed({1'b0, mario_r}) + $signed({{9{step_vel_s[7]}}, step_vel_s});
    if (mario_sum_s[16]) begin
      step_mario_s = 16'd0;
    end else if (mario_sum_s > GROUND_S) begin
      step_mario_s = GROUND_V;
    end else begin
      step_mario_s = mario_sum_s[15:0];
    end
    my_s = $signed({2'b00, step_mario_s});

    for (int i = 0; i < 3; i++) begin
      nx_s[i]   = pipe_x_r[i] - SPEED_V;
      // Pass judged on the scrolled x, before any wrap-around
      pass_s[i] = (sext18(pipe_x_r[i]) + PIPE_W_S >= BIRD_X_S) &&
                  (sext18(nx_s[i]) + PIPE_W_S < BIRD_X_S);
      if (sext18(nx_s[i]) <= -PIPE_W_S) begin
        step_px_s[i]  = nx_s[i] + SPAN_V;
        step_gap_s[i] = GAP_MIN_V + {8'h00, lfsr_s[7:0]};
        respawn_s[i]  = 1'b1;
      end else begin
        step_px_s[i]  = nx_s[i];
        step_gap_s[i] = pipe_gap_r[i];
        respawn_s[i]  = 1'b0;
      end
    end

    // A visible coin scrolls; a hidden one reappears at the first respawned pipe
    if (coin_y_r != COIN_HIDDEN_Y) begin
      cx_s = coin_x_r - SPEED_V;
      if (sext18(cx_s) <= -COIN_W_S) begin
        step_cx_s = COIN_HIDDEN[31:16];
        step_cy_s = COIN_HIDDEN_Y;
      end else begin
        step_cx_s = cx_s;
        step_cy_s = coin_y_r;
      end
    end else if (respawn_s[0]) begin
      step_cx_s = step_px_s[0] + COIN_DX;
      step_cy_s = step_gap_s[0] + COIN_DY;
    end else if (respawn_s[1]) begin
      step_cx_s = step_px_s[1] + COIN_DX;
      step_cy_s = step_gap_s[1] + COIN_DY;
    end else if (respawn_s[2]) begin
      step_cx_s = step_px_s[2] + COIN_DX;
      step_cy_s = step_gap_s[2] + COIN_DY;
    end else begin
      step_cx_s = coin_x_r;
      step_cy_s = coin_y_r;
    end

    cx18_s = sext18(step_cx_s);
    cy18_s = $signed({2'b00, step_cy_s});
    pickup_s = (step_cy_s != COIN_HIDDEN_Y) &&
               (cx18_s < BIRD_X_S + BIRD_W_S) && (cx18_s + COIN_W_S > BIRD_X_S) &&
               (cy18_s < my_s + BIRD_W_S) && (cy18_s + COIN_W_S > my_s);
    if (pickup_s) begin
      step_cx_s = COIN_HIDDEN[31:16];
      step_cy_s = COIN_HIDDEN_Y;
    end else begin
      step_cx_s = step_cx_s;
    end

    collide_s = (step_mario_s == GROUND_V);
    for (int i = 0; i < 3; i++) begin
      collide_s = collide_s |
        ((sext18(step_px_s[i]) < BIRD_X_S + BIRD_W_S) &&
         (sext18(step_px_s[i]) + PIPE_W_S > BIRD_X_S) &&
         ((my_s < $signed({2'b00, step_gap_s[i]})) ||
          (my_s + BIRD_W_S > $signed({2'b00, step_gap_s[i]}) + GAP_H_S)));
    end

    inc_s = {2'b00, pass_s[0]} + {2'b00, pass_s[1]} + {2'b00, pass_s[2]} + {2'b00, pickup_s};
    step_score_s = bcd_sat_add(score_r, inc_s);
  end

  // Next game state; a button transition suppresses that cycle's motion step
  always_comb begin
    next_state_s = state_r;
    btn_trans_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_edge_s) begin
          next_state_s = ST_RUN;
          btn_trans_s  = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (pause_edge_s) begin
          next_state_s = ST_PAUSE;
          btn_trans_s  = 1'b1;
        end else if (frame_tick && collide_s) begin
          next_state_s = ST_OVER;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (pause_edge_s) begin
          next_state_s = ST_RUN;
          btn_trans_s  = 1'b1;
        end else begin
          next_state_s = ST_PAUSE;
        end
      end
      ST_OVER: begin
        if (start_edge_s) begin
          next_state_s = ST_IDLE;
          btn_trans_s  = 1'b1;
        end else begin
          next_state_s = ST_OVER;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  assign run_step_s   = (state_r == ST_RUN) && frame_tick && !btn_trans_s;
  assign enter_idle_s = (state_r == ST_OVER) && (next_state_s == ST_IDLE);

  // State register, button history and pending-flap flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      flap_r    <= 1'b0;
      flap_q_r  <= 1'b0;
      start_q_r <= 1'b0;
      pause_q_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      flap_q_r  <= btn_flap;
      start_q_r <= btn_start;
      pause_q_r <= btn_pause;
      if (next_state_s != state_r) begin
        flap_r <= 1'b0;
      end else if (flap_edge_s) begin
        flap_r <= 1'b1;
      end else if (run_step_s) begin
        flap_r <= 1'b0;
      end
    end
  end

  // Playfield registers: restored on reset or entering IDLE, stepped on RUN ticks
  always_ff @(posedge clk) begin
    if (rst || enter_idle_s) begin
      score_r  <= 16'h0000;
      mario_r  <= MARIO0;
      vel_r    <= 8'sd0;
      pipe_x_r[0] <= PX1;
      pipe_x_r[1] <= PX2;
      pipe_x_r[2] <= PX3;
      for (int i = 0; i < 3; i++) begin
        pipe_gap_r[i] <= GAP0;
      end
      coin_x_r <= COIN_HIDDEN[31:16];
      coin_y_r <= COIN_HIDDEN_Y;
    end else if (run_step_s) begin
      score_r  <= step_score_s;
      mario_r  <= step_mario_s;
      vel_r    <= step_vel_s;
      for (int i = 0; i < 3; i++) begin
        pipe_x_r[i]   <= step_px_s[i];
        pipe_gap_r[i] <= step_gap_s[i];
      end
      coin_x_r <= step_cx_s;
      coin_y_r <= step_cy_s;
    end
  end

  assign status = state_r;
  assign score  = score_r;
  assign mario  = mario_r;
  assign pipe_1 = {pipe_x_r[0], pipe_gap_r[0]};
  assign pipe_2 = {pipe_x_r[1], pipe_gap_r[1]};
  assign pipe_3 = {pipe_x_r[2], pipe_gap_r[2]};
  assign coin   = {coin_x_r, coin_y_r};

endmodule
